axis_fork_dispatch: RTL

Parametrised AXI-Stream 1-to-M fork with three dispatch modes: unicast, per-beat round-robin, and broadcast.
- Each output has a one-entry registered slot, so outputs drain independently.
- After each frame, an all-ones trailer word with tlast is optionally sent to every enabled output.
- Sits between the input DMA stream and the per-core PAICORE lanes, replacing the combinational fork arbiter.

---
 rtl/axis_fork_pkg.sv | 31 +++
 rtl/axis_fork_slot.sv | 31 +++
 rtl/axis_fork_dispatch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/axis_fork_pkg.sv
// Shared encodings and the circular priority search for the AXI-Stream fork dispatcher.
// The search is sized for the 16-channel maximum; callers zero-pad narrower vectors.
package axis_fork_pkg;

   localparam logic [1:0] MODE_UNICAST = 2'd0;
   localparam logic [1:0] MODE_RR      = 2'd1;
   localparam logic [1:0] MODE_BCAST   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DATA    = 2'd1,
      S_TRAILER = 2'd2
   } state_t;

   // Returns {found, index} of the first set bit of cand at or after ptr, wrapping at m.
   // Iterating from the far end lets the nearest candidate overwrite the result last.
   function automatic logic [4:0] rr_pick(input logic [15:0] cand,
                                          input logic [3:0]  ptr,
                                          input int unsigned m);
      logic [4:0] idx;
      logic [4:0] res;
      res = '0;
      for (int k = 15; k >= 0; k--) begin
         idx = {1'b0, ptr} + 5'(k);
         if (idx >= 5'(m)) idx = idx - 5'(m);
         if (k < int'(m) && cand[idx[3:0]]) res = {1'b1, idx[3:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/axis_fork_slot.sv
// One-entry registered output slot with AXI-Stream valid/ready.
// A load in the same cycle as a drain refills the slot, so it sustains one beat per cycle.
module axis_fork_slot #(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   input  logic                  ready,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  last
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         last  <= load_last;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_fork_dispatch.sv
// AXI-Stream 1-to-M fork: unicast, per-beat round-robin or broadcast into per-output slots,
// with an optional all-ones trailer beat to every enabled output after each frame.
module axis_fork_dispatch
   import axis_fork_pkg::*;
#(
   parameter int unsigned           M_COUNT      = 4,
   parameter int unsigned           DATA_WIDTH   = 64,
   parameter bit                    TRAILER_EN   = 1'b1,
   parameter logic [DATA_WIDTH-1:0] TRAILER_WORD = '1,
   parameter int unsigned           CNT_W        = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    mode,
   input  logic [M_COUNT-1:0]            chan_mask,
   input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
   input  logic                          s_axis_tlast,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
   output logic [M_COUNT-1:0]            m_axis_tlast,
   output logic [M_COUNT-1:0]            m_axis_tvalid,
   input  logic [M_COUNT-1:0]            m_axis_tready,
   output logic                          busy,
   output logic [CNT_W-1:0]              frame_count
);

   state_t                  state_q, state_d;
   logic [1:0]              mode_q, eff_mode;
   logic [M_COUNT-1:0]      mask_q, eff_mask;
   logic [M_COUNT-1:0]      slot_vld, can_acc, load;
   logic [3:0]              ptr_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [15:0]             mask16, can16, load16;
   logic [4:0]              uni_sel, rr_sel;
   logic                    data_phase, data_rdy, bcast_ok, hs, trl_fire, start;
   logic [DATA_WIDTH-1:0]   load_data;
   logic                    load_last;

   assign can_acc = ~slot_vld | m_axis_tready;
   assign start   = (state_q == S_IDLE) && s_axis_tvalid && (chan_mask != '0);

   always_comb begin
      // In IDLE the first beat is dispatched with the values about to be latched.
      eff_mode   = (state_q == S_IDLE) ? mode      : mode_q;
      eff_mask   = (state_q == S_IDLE) ? chan_mask : mask_q;
      mask16     = 16'(eff_mask);
      can16      = 16'(can_acc);
      uni_sel    = rr_pick(mask16, 4'd0, M_COUNT);
      rr_sel     = rr_pick(mask16 & can16, ptr_q, M_COUNT);
      bcast_ok   = &(can16 | ~mask16);
      data_phase = ((state_q == S_IDLE) && (chan_mask != '0)) || (state_q == S_DATA);

      data_rdy = 1'b0;
      load16   = '0;
      case (eff_mode)
         MODE_UNICAST: begin
            data_rdy = uni_sel[4] && can16[uni_sel[3:0]];
            load16   = 16'd1 << uni_sel[3:0];
         end
         MODE_RR: begin
            data_rdy = rr_sel[4];
            load16   = 16'd1 << rr_sel[3:0];
         end
         default: begin
            data_rdy = bcast_ok;
            load16   = mask16;
         end
      endcase

      s_axis_tready = data_phase && data_rdy;
      hs            = s_axis_tvalid && s_axis_tready;
      trl_fire      = (state_q == S_TRAILER) && bcast_ok;

      load      = '0;
      load_data = s_axis_tdata;
      load_last = TRAILER_EN ? 1'b0 : s_axis_tlast;
      if (hs) begin
         load = load16[M_COUNT-1:0];
      end else if (trl_fire) begin
         load      = mask_q;
         load_data = TRAILER_WORD;
         load_last = 1'b1;
      end

      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_DATA;
         S_TRAILER: if (trl_fire) state_d = S_IDLE;
         default:   ;
      endcase
      if (hs && s_axis_tlast) state_d = TRAILER_EN ? S_TRAILER : S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= MODE_UNICAST;
         mask_q <= '0;
         ptr_q  <= '0;
         cnt_q  <= '0;
      end else begin
         if (start) begin
            mode_q <= mode;
            mask_q <= chan_mask;
         end
         if (hs && eff_mode == MODE_RR)
            ptr_q <= ({1'b0, rr_sel[3:0]} == 5'(M_COUNT - 1)) ? 4'd0 : rr_sel[3:0] + 4'd1;
         if (hs && s_axis_tlast)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   for (genvar i = 0; i < M_COUNT; i++) begin : g_slot
      axis_fork_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
         .clk       (clk),
         .rst       (rst),
         .load      (load[i]),
         .load_data (load_data),
         .load_last (load_last),
         .ready     (m_axis_tready[i]),
         .valid     (slot_vld[i]),
         .data      (m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
         .last      (m_axis_tlast[i])
      );
   end

   assign m_axis_tvalid = slot_vld;
   assign busy          = (state_q != S_IDLE) || (|slot_vld);
   assign frame_count   = cnt_q;

endmodule
